// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e : controller state encoding (IDLE / RUN / DONE)
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_fa_cell.sv
// Combinational full-add bit cell used by the bit-serial adder.
// It is built from two half adders, and an OR gate merges their carries.
//   serial_ha      : x, y       -> s = x^y,     c = x&y
//   serial_fa_cell : x, y, cin  -> s = x^y^cin, cout = majority(x, y, cin)
module serial_ha (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule : serial_ha

module serial_fa_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   serial_ha u_ha0 (.x(x),  .y(y),   .s(s0), .c(c0));
   serial_ha u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

   // The two half-adder carries can never both be 1, so OR equals majority.
   assign cout = c0 | c1;

endmodule : serial_fa_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. It adds two WIDTH-bit operands one bit per
// clock, LSB first, through a single shared full-add cell and a registered
// carry.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : operand handshake (a, b sampled on it)
//   rsp_valid/rsp_ready  : result handshake (sum, cout held while waiting)
//   sum, cout            : registered result, a+b mod 2^WIDTH and carry out
//   busy                 : high while bits are being processed
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q,  a_sh_d;
   logic [WIDTH-1:0] b_sh_q,  b_sh_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q,  cout_d;

   logic fa_s;
   logic fa_c;

   serial_fa_cell u_fa (
      .x    (a_sh_q[0]),
      .y    (b_sh_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               sum_d   = '0;
               cnt_d   = '0;
               carry_d = 1'b0;
               cout_d  = 1'b0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            busy    = 1'b1;
            // The new bit enters at the MSB. After WIDTH shifts the LSB sum bit reaches bit 0.
            sum_d            = sum_q >> 1;
            sum_d[WIDTH-1]   = fa_s;
            a_sh_d           = a_sh_q >> 1;
            b_sh_d           = b_sh_q >> 1;
            carry_d          = fa_c;
            cnt_d            = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               cout_d  = fa_c;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment, so every flop samples the pre-edge values.
      if (rst) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl. It uses one WIDTH=8 instance and
// one WIDTH=1 instance, both on the same clock and reset.
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst;

   // WIDTH=8 instance
   logic       req_valid, req_ready, rsp_valid, rsp_ready, cout, busy;
   logic [7:0] a, b, sum;

   // WIDTH=1 instance
   logic       req_valid1, req_ready1, rsp_valid1, rsp_ready1, cout1, busy1;
   logic [0:0] a1, b1, sum1;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .a(a), .b(b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   serial_add_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_ready(req_ready1), .a(a1), .b(b1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation on the 8-bit instance, with rsp_ready held high.
   task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] es, input logic ec, input string tag);
      int edges;
      int busy_cycles;
      check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; a = av; b = bv; rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0; a = 8'h00; b = 8'h00;
      edges = 0; busy_cycles = 0;
      while (!rsp_valid && edges < 40) begin
         busy_cycles += int'(busy);
         tick();
         edges++;
      end
      check({tag, " latency"},   32'(edges),       32'd8);
      check({tag, " busy cyc"},  32'(busy_cycles), 32'd8);
      check({tag, " sum"},       32'(sum),         32'(es));
      check({tag, " cout"},      32'(cout),        32'(ec));
      check({tag, " req_ready done"}, 32'(req_ready), 32'd0);
      tick();
      check({tag, " rsp_valid after take"}, 32'(rsp_valid), 32'd0);
      check({tag, " req_ready after take"}, 32'(req_ready), 32'd1);
   endtask

   task automatic do_op1(input logic av, input logic bv,
                         input logic es, input logic ec, input string tag);
      int edges;
      req_valid1 = 1'b1; a1 = av; b1 = bv; rsp_ready1 = 1'b1;
      tick();
      req_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      edges = 0;
      while (!rsp_valid1 && edges < 10) begin
         tick();
         edges++;
      end
      check({tag, " latency"}, 32'(edges), 32'd1);
      check({tag, " sum"},     32'(sum1),  32'(es));
      check({tag, " cout"},    32'(cout1), 32'(ec));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      vecs[0] = '{a: 8'h5A, b: 8'hA5, sum: 8'hFF, cout: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
      vecs[2] = '{a: 8'hC8, b: 8'h64, sum: 8'h2C, cout: 1'b1};
      vecs[3] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1};
      vecs[4] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
      vecs[5] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0};

      rst = 1'b1;
      req_valid = 1'b0; a = '0; b = '0; rsp_ready = 1'b0;
      req_valid1 = 1'b0; a1 = '0; b1 = '0; rsp_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) tick();

      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset busy",      32'(busy),      32'd0);
      check("reset sum",       32'(sum),       32'h00);
      check("reset cout",      32'(cout),      32'd0);
      check("reset w1 req_ready", 32'(req_ready1), 32'd1);
      check("reset w1 rsp_valid", 32'(rsp_valid1), 32'd0);

      // Table-driven operations, run back to back so carry clearing is exercised.
      for (int i = 0; i < 6; i++) begin
         do_op8(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));
      end

      // Backpressure: hold rsp_ready low and drive different operands with req_valid high.
      rsp_ready = 1'b0;
      req_valid = 1'b1; a = 8'h3C; b = 8'h0F;
      tick();
      a = 8'hFF; b = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp run%0d req_ready", i), 32'(req_ready), 32'd0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp hold%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
         check($sformatf("bp hold%0d sum", i),       32'(sum),       32'h4B);
         check($sformatf("bp hold%0d cout", i),      32'(cout),      32'd0);
         check($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
         tick();
      end
      req_valid = 1'b0; a = 8'h00; b = 8'h00; rsp_ready = 1'b1;
      tick();
      check("bp released rsp_valid", 32'(rsp_valid), 32'd0);
      check("bp sum retained",       32'(sum),       32'h4B);
      check("bp req_ready idle",     32'(req_ready), 32'd1);

      // Reset abort during the 4th RUN cycle of 0x12 + 0x34.
      req_valid = 1'b1; a = 8'h12; b = 8'h34; rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0; a = 8'h00; b = 8'h00;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort req_ready", 32'(req_ready), 32'd1);
      check("abort busy",      32'(busy),      32'd0);
      check("abort rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort sum",       32'(sum),       32'h00);
      check("abort cout",      32'(cout),      32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid) seen = 1;
         tick();
      end
      check("abort no rsp_valid", 32'(seen), 32'd0);
      do_op8(8'h12, 8'h34, 8'h46, 1'b0, "after abort");

      // WIDTH=1 instance: all four operand combinations.
      do_op1(1'b0, 1'b0, 1'b0, 1'b0, "w1 0+0");
      do_op1(1'b0, 1'b1, 1'b1, 1'b0, "w1 0+1");
      do_op1(1'b1, 1'b0, 1'b1, 1'b0, "w1 1+0");
      do_op1(1'b1, 1'b1, 1'b0, 1'b1, "w1 1+1");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_serial_add_ctrl
